fmult_accum_seq: RTL and testbench

//  Sequential G.726 FMULT+ACCUM engine for the multi-channel ADPCM datapath. On start, reads
//  N_ZERO+N_POLE (coef, float-operand) tap pairs from an external 1-cycle-latency store,

---
 rtl/fmult_accum_seq_pkg.sv | 31 +++
 rtl/fmult_core.sv | 48 ++++
 rtl/fmult_accum_seq.sv | 175 +++++++++++++++++
 tb/tb_fmult_accum_seq.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fmult_accum_seq_pkg.sv
// Shared types and constants for the sequential FMULT+ACCUM predictor engine.
package adpcm_pkg;

    localparam int FLT_W  = 11;
    localparam int COEF_W = 16;
    localparam int WAN_W  = 16;

    // G.726 floating-point operand as held in the DQn / SRn store.
    typedef struct packed {
        logic       sign;
        logic [3:0] expn;
        logic [5:0] mant;
    } flt_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Exponent of a 13-bit magnitude: 0 for zero, otherwise 1 + index of the top set bit.
    function automatic logic [3:0] msb_pos(input logic [12:0] v);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 0; i < 13; i++) begin
            if (v[i]) r = 4'(i + 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/fmult_core.sv
// Combinational G.726 FMULT: coefficient x float operand -> 16-bit two's-complement WAn.
module fmult_core
    import adpcm_pkg::*;
(
    input  logic [COEF_W-1:0] coef_i,
    input  logic [FLT_W-1:0]  flt_i,
    output logic [WAN_W-1:0]  wan_o
);

    flt_t        flt;
    logic        an_s;
    logic [15:0] an_neg;
    logic [12:0] an_mag;
    logic [3:0]  an_exp;
    logic [5:0]  an_mant;
    logic        ws;
    logic [4:0]  wexp;
    logic [11:0] prod;
    logic [7:0]  wmant;
    logic [16:0] wm_ext;
    logic [14:0] wmag;

    assign flt = flt_t'(flt_i);

    // Coefficient to float, float multiply, then back to a fixed-point signed product.
    always_comb begin
        an_s    = coef_i[15];
        an_neg  = -coef_i;
        // Magnitude drops the two LSBs; the 0x8000 case masks down to zero.
        an_mag  = an_s ? 13'(an_neg >> 2) : 13'(coef_i >> 2);
        an_exp  = msb_pos(an_mag);
        an_mant = (an_mag == 13'd0) ? 6'd32 : 6'({an_mag, 6'b0} >> an_exp);
        ws      = an_s ^ flt.sign;
        wexp    = {1'b0, an_exp} + {1'b0, flt.expn};
        prod    = ({6'b0, flt.mant} * {6'b0, an_mant}) + 12'd48;
        wmant   = 8'(prod >> 4);
        wm_ext  = {2'b0, wmant, 7'b0};
        // Exponent above 26 shifts left and the result is truncated to 15 bits.
        if (wexp <= 5'd26) begin
            wm_ext = wm_ext >> (5'd26 - wexp);
        end else begin
            wm_ext = wm_ext << (wexp - 5'd26);
        end
        wmag  = 15'(wm_ext);
        wan_o = ws ? -{1'b0, wmag} : {1'b0, wmag};
    end

endmodule

// File: rtl/fmult_accum_seq.sv
// Sequential predictor estimate: one shared FMULT walks all taps and accumulates SEZ / SE.
//
// Handshake: start is a single-cycle request accepted only while busy is low (state IDLE);
// requests while busy, including the done cycle, are dropped. Each tap_rd pulse returns
// coef_in/flt_in exactly one cycle later. done pulses for one cycle with results valid;
// sez/se/ch_out then hold until the next run completes.
module fmult_accum_seq
    import adpcm_pkg::*;
#(
    parameter  int N_ZERO = 6,
    parameter  int N_POLE = 2,
    parameter  int N_CH   = 32,
    localparam int CH_W   = $clog2(N_CH),
    localparam int TAP_W  = $clog2(N_ZERO + N_POLE)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CH_W-1:0]   ch_in,
    input  logic              sez_only,
    output logic [TAP_W-1:0]  tap_addr,
    output logic              tap_rd,
    input  logic [COEF_W-1:0] coef_in,
    input  logic [FLT_W-1:0]  flt_in,
    output logic              busy,
    output logic              done,
    output logic [CH_W-1:0]   ch_out,
    output logic [14:0]       sez,
    output logic [14:0]       se,
    input  logic              scan_in0,
    input  logic              scan_in1,
    input  logic              scan_in2,
    input  logic              scan_in3,
    input  logic              scan_in4,
    input  logic              scan_enable,
    input  logic              test_mode,
    output logic              scan_out0,
    output logic              scan_out1,
    output logic              scan_out2,
    output logic              scan_out3,
    output logic              scan_out4
);

    localparam logic [TAP_W-1:0] ZERO_LAST = TAP_W'(N_ZERO - 1);
    localparam logic [TAP_W-1:0] ALL_LAST  = TAP_W'(N_ZERO + N_POLE - 1);

    state_e            state_q, state_d;
    logic              busy_c, done_c;
    logic              accept;
    logic              last_prod;
    logic [TAP_W-1:0]  last_addr;

    logic              tap_rd_q;
    logic [TAP_W-1:0]  tap_addr_q;
    logic              vld_q;
    logic [TAP_W-1:0]  vld_addr_q;
    logic [WAN_W-1:0]  acc_q;
    logic [WAN_W-1:0]  sezi_q;
    logic [CH_W-1:0]   ch_run_q;
    logic              sez_only_q;
    logic [CH_W-1:0]   ch_out_q;
    logic [14:0]       sez_q, se_q;

    logic [WAN_W-1:0]  wan;
    logic [WAN_W-1:0]  acc_sum;
    logic [WAN_W-1:0]  sezi_next;

    fmult_core u_fmult (
        .coef_i (coef_in),
        .flt_i  (flt_in),
        .wan_o  (wan)
    );

    assign accept    = start && (state_q == ST_IDLE);
    assign last_addr = sez_only_q ? ZERO_LAST : ALL_LAST;
    assign last_prod = vld_q && (vld_addr_q == last_addr);
    assign acc_sum   = acc_q + wan;
    assign sezi_next = (vld_addr_q == ZERO_LAST) ? acc_sum : sezi_q;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and status outputs.
    always_comb begin
        state_d = state_q;
        busy_c  = 1'b1;
        done_c  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                busy_c = 1'b0;
                if (start) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (last_prod) state_d = ST_DONE;
            end
            ST_DONE: begin
                done_c  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                busy_c  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Tap issue, one-cycle read pipeline, accumulation and result capture.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tap_rd_q   <= 1'b0;
            tap_addr_q <= '0;
            vld_q      <= 1'b0;
            vld_addr_q <= '0;
            acc_q      <= '0;
            sezi_q     <= '0;
            ch_run_q   <= '0;
            sez_only_q <= 1'b0;
            ch_out_q   <= '0;
            sez_q      <= '0;
            se_q       <= '0;
        end else begin
            vld_q      <= tap_rd_q;
            vld_addr_q <= tap_addr_q;

            if (accept) begin
                tap_rd_q   <= 1'b1;
                tap_addr_q <= '0;
                acc_q      <= '0;
                sezi_q     <= '0;
                ch_run_q   <= ch_in;
                sez_only_q <= sez_only;
            end else if (tap_rd_q) begin
                if (tap_addr_q == last_addr) begin
                    tap_rd_q <= 1'b0;
                end else begin
                    tap_addr_q <= tap_addr_q + 1'b1;
                end
            end

            if (vld_q) begin
                acc_q  <= acc_sum;
                sezi_q <= sezi_next;
            end

            // The zero-section snapshot may land on this same edge in sez_only mode.
            if (last_prod) begin
                ch_out_q <= ch_run_q;
                sez_q    <= 15'(sezi_next >> 1);
                se_q     <= sez_only_q ? 15'(sezi_next >> 1) : 15'(acc_sum >> 1);
            end
        end
    end

    assign tap_rd   = tap_rd_q;
    assign tap_addr = tap_addr_q;
    assign busy     = busy_c;
    assign done     = done_c;
    assign ch_out   = ch_out_q;
    assign sez      = sez_q;
    assign se       = se_q;

    // Scan chains are stitched at DFT insertion; functional mode holds them low.
    assign scan_out0 = scan_in0 & scan_enable & test_mode;
    assign scan_out1 = scan_in1 & scan_enable & test_mode;
    assign scan_out2 = scan_in2 & scan_enable & test_mode;
    assign scan_out3 = scan_in3 & scan_enable & test_mode;
    assign scan_out4 = scan_in4 & scan_enable & test_mode;

endmodule

// File: tb/tb_fmult_accum_seq.sv
// Bench for fmult_accum_seq: directed table, corner sequences, random sweep vs reference model.
module tb_fmult_accum_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [4:0]  ch_in;
    logic        sez_only;
    logic [2:0]  tap_addr;
    logic        tap_rd;
    logic [15:0] coef_in;
    logic [10:0] flt_in;
    logic        busy;
    logic        done;
    logic [4:0]  ch_out;
    logic [14:0] sez;
    logic [14:0] se;
    logic        scan_in0, scan_in1, scan_in2, scan_in3, scan_in4;
    logic        scan_enable, test_mode;
    logic        scan_out0, scan_out1, scan_out2, scan_out3, scan_out4;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [15:0] mem_coef [8];
    logic [10:0] mem_flt  [8];
    logic [2:0]  rd_addr_q [$];
    int          rd_cyc_q  [$];
    logic [34:0] exp_q [$];

    logic [14:0] prev_sez, prev_se;
    logic [4:0]  prev_ch;

    typedef struct packed {
        logic [7:0][15:0] coef;
        logic [7:0][10:0] flt;
        logic             so;
        logic [4:0]       ch;
        logic [14:0]      sez;
        logic [14:0]      se;
    } vec_t;

    vec_t vecs [6];

    fmult_accum_seq dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .ch_in       (ch_in),
        .sez_only    (sez_only),
        .tap_addr    (tap_addr),
        .tap_rd      (tap_rd),
        .coef_in     (coef_in),
        .flt_in      (flt_in),
        .busy        (busy),
        .done        (done),
        .ch_out      (ch_out),
        .sez         (sez),
        .se          (se),
        .scan_in0    (scan_in0),
        .scan_in1    (scan_in1),
        .scan_in2    (scan_in2),
        .scan_in3    (scan_in3),
        .scan_in4    (scan_in4),
        .scan_enable (scan_enable),
        .test_mode   (test_mode),
        .scan_out0   (scan_out0),
        .scan_out1   (scan_out1),
        .scan_out2   (scan_out2),
        .scan_out3   (scan_out3),
        .scan_out4   (scan_out4)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Coefficient/operand store with one-cycle read latency; logs every read strobe.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tap_rd) begin
            coef_in <= mem_coef[tap_addr];
            flt_in  <= mem_flt[tap_addr];
            rd_addr_q.push_back(tap_addr);
            rd_cyc_q.push_back(cyc);
        end else begin
            coef_in <= 16'($urandom);
            flt_in  <= 11'($urandom);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // G.726 FMULT straight from its arithmetic definition.
    function automatic int fmult_ref(input int coef, input int flt);
        int an_s, mag, aexp, amant, ws, wexp, wmant, wmag, t;
        an_s = (coef >> 15) & 1;
        mag  = an_s ? ((((65536 - coef) & 16'hFFFF) >> 2) & 16'h1FFF) : (coef >> 2);
        aexp = 0;
        t    = mag;
        while (t > 0) begin
            aexp++;
            t = t >> 1;
        end
        amant = (mag == 0) ? 32 : ((mag << 6) >> aexp);
        ws    = an_s ^ ((flt >> 10) & 1);
        wexp  = aexp + ((flt >> 6) & 15);
        wmant = (((flt & 63) * amant) + 48) >> 4;
        if (wexp <= 26) wmag = (wmant << 7) >> (26 - wexp);
        else            wmag = ((wmant << 7) << (wexp - 26)) & 16'h7FFF;
        return ws ? ((65536 - wmag) & 16'hFFFF) : wmag;
    endfunction

    task automatic model(input logic so, output logic [14:0] es, output logic [14:0] ee);
        int sezi, sei;
        sezi = 0;
        for (int i = 0; i < 6; i++) sezi = (sezi + fmult_ref(int'(mem_coef[i]), int'(mem_flt[i]))) % 65536;
        sei = sezi;
        for (int i = 6; i < 8; i++) sei = (sei + fmult_ref(int'(mem_coef[i]), int'(mem_flt[i]))) % 65536;
        if (so) sei = sezi;
        es = 15'(sezi >> 1);
        ee = 15'(sei >> 1);
    endtask

    task automatic load_vec(input vec_t v);
        for (int i = 0; i < 8; i++) begin
            mem_coef[i] = v.coef[i];
            mem_flt[i]  = v.flt[i];
        end
    endtask

    task automatic check_reads(input string tag, input int len, input int t0);
        int bad;
        bad = 0;
        if (rd_addr_q.size() != len) bad++;
        else begin
            for (int i = 0; i < len; i++) begin
                if (int'(rd_addr_q[i]) != i || rd_cyc_q[i] != t0 + 1 + i) bad++;
            end
        end
        check({tag, "_reads"}, bad, 0);
    endtask

    // One full run: start, wait (bounded) for done, compare against the expected queue.
    task automatic run_op(input logic [4:0] ch, input logic so,
                          input logic [14:0] es, input logic [14:0] ee, input string tag);
        int t0, lat, hold_bad;
        logic [34:0] e;
        exp_q.push_back({ch, es, ee});
        rd_addr_q.delete();
        rd_cyc_q.delete();
        @(negedge clk);
        start = 1'b1; ch_in = ch; sez_only = so; t0 = cyc;
        lat = -1; hold_bad = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                lat = cyc - t0;
                break;
            end
            if (sez !== prev_sez || se !== prev_se || ch_out !== prev_ch) hold_bad++;
        end
        e = exp_q.pop_front();
        check({tag, "_lat"}, lat, so ? 8 : 10);
        check({tag, "_hold"}, hold_bad, 0);
        check({tag, "_ch"}, ch_out, e[34:30]);
        check({tag, "_sez"}, sez, e[29:15]);
        check({tag, "_se"}, se, e[14:0]);
        check_reads(tag, so ? 6 : 8, t0);
        prev_sez = e[29:15]; prev_se = e[14:0]; prev_ch = e[34:30];
    endtask

    initial begin
        int t0, dcnt, done_at;
        logic [14:0] es, ee;
        logic so;

        reset = 1'b0; start = 1'b0; ch_in = '0; sez_only = 1'b0;
        scan_in0 = 0; scan_in1 = 0; scan_in2 = 0; scan_in3 = 0; scan_in4 = 0;
        scan_enable = 0; test_mode = 0;
        coef_in = '0; flt_in = '0;
        for (int i = 0; i < 8; i++) begin mem_coef[i] = '0; mem_flt[i] = '0; end
        prev_sez = '0; prev_se = '0; prev_ch = '0;

        // Directed vectors
        vecs[0] = '{coef: {8{16'h1000}}, flt: {8{11'h3E0}}, so: 1'b0, ch: 5'd0, sez: 15'h6480, se: 15'h0600};
        vecs[1] = '{coef: '0, flt: '0, so: 1'b0, ch: 5'd1, sez: 15'h6F40, se: 15'h6F40};
        vecs[1].coef[2] = 16'hF000; vecs[1].flt[2] = 11'h3E0;
        vecs[2] = '{coef: '0, flt: '0, so: 1'b0, ch: 5'd2, sez: 15'h0000, se: 15'h6F40};
        vecs[2].coef[7] = 16'hF000; vecs[2].flt[7] = 11'h3E0;
        vecs[3] = '{coef: {8{16'h1000}}, flt: {8{11'h3E0}}, so: 1'b1, ch: 5'd5, sez: 15'h6480, se: 15'h6480};
        vecs[4] = '{coef: '0, flt: '0, so: 1'b0, ch: 5'd31, sez: 15'h7FFE, se: 15'h7FFE};
        vecs[4].coef[0] = 16'h8000; vecs[4].flt[0] = 11'h3E0;
        vecs[5] = '{coef: '0, flt: '0, so: 1'b0, ch: 5'd17, sez: 15'h3B00, se: 15'h3B00};
        vecs[5].coef[1] = 16'h7FFC; vecs[5].flt[1] = 11'h3FF;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_tap_rd", tap_rd, 0);
        check("rst_tap_addr", tap_addr, 0);
        check("rst_sez", sez, 0);
        check("rst_se", se, 0);
        check("rst_ch", ch_out, 0);
        reset = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            load_vec(vecs[v]);
            run_op(vecs[v].ch, vecs[v].so, vecs[v].sez, vecs[v].se, $sformatf("vec%0d", v));
        end

        // Starts at t+3 and in the done cycle must both be dropped.
        load_vec(vecs[0]);
        rd_addr_q.delete(); rd_cyc_q.delete();
        @(negedge clk);
        start = 1'b1; ch_in = 5'd3; sez_only = 1'b0; t0 = cyc;
        dcnt = 0; done_at = -1;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == t0 + 3) start = 1'b1;
            if (done) begin
                dcnt++;
                if (done_at < 0) begin
                    done_at = cyc - t0;
                    start = 1'b1;
                end
            end
        end
        start = 1'b0;
        check("ign_done_cnt", dcnt, 1);
        check("ign_lat", done_at, 10);
        check("ign_sez", sez, 15'h6480);
        check("ign_se", se, 15'h0600);
        check("ign_ch", ch_out, 5'd3);
        check("ign_busy", busy, 0);
        check_reads("ign", 8, t0);
        prev_sez = 15'h6480; prev_se = 15'h0600; prev_ch = 5'd3;

        // Reset in the middle of a run aborts it.
        load_vec(vecs[0]);
        @(negedge clk);
        start = 1'b1; ch_in = 5'd7; sez_only = 1'b0; t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_tap_rd", tap_rd, 0);
        check("abort_sez", sez, 0);
        check("abort_se", se, 0);
        check("abort_ch", ch_out, 0);
        reset = 1'b1;
        dcnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("abort_no_done", dcnt, 0);
        prev_sez = '0; prev_se = '0; prev_ch = '0;
        run_op(5'd7, 1'b0, 15'h6480, 15'h0600, "after_abort");

        // Random sweep over all channels
        for (int n = 0; n < 2500; n++) begin
            for (int i = 0; i < 8; i++) begin
                case ($urandom_range(0, 9))
                    0:       mem_coef[i] = 16'h0000;
                    1:       mem_coef[i] = 16'h8000;
                    2:       mem_coef[i] = 16'h7FFF;
                    3:       mem_coef[i] = 16'hFFFF;
                    default: mem_coef[i] = 16'($urandom);
                endcase
                mem_flt[i] = 11'($urandom_range(0, 2047));
            end
            so = ($urandom_range(0, 3) == 0);
            model(so, es, ee);
            run_op(5'(n % 32), so, es, ee, "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
